hazard3_ahbl_arbiter2: RTL

//  Two-source AHB-Lite arbiter: shares one downstream AHB-Lite master port between two upstream
//  AHB-Lite masters (e.g. two single-port Hazard3 cores, or a core plus a DMA). A source that loses

---
 rtl/hazard3_ahbl_arbiter2_pkg.sv | 20 ++
 rtl/hazard3_ahbl_aph_buf.sv | 54 +++++
 rtl/hazard3_ahbl_arbiter2.sv | 128 ++++++++++++
 3 files changed

// File: rtl/hazard3_ahbl_arbiter2_pkg.sv
// rtl/hazard3_ahbl_arbiter2_pkg.sv - shared AHB-Lite encodings and arbitration helper
package hazard3_ahbl_arbiter2_pkg;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;

  // Returns a one-hot grant; last_gnt1 says source 1 won the previous issued aph.
  function automatic logic [1:0] arb_pick(
    input logic [1:0] req,
    input logic       last_gnt1,
    input logic       round_robin
  );
    logic [1:0] gnt;
    gnt = req;
    if (req == 2'b11)
      gnt = (round_robin && !last_gnt1) ? 2'b10 : 2'b01;
    return gnt;
  endfunction

endpackage

// File: rtl/hazard3_ahbl_aph_buf.sv
// rtl/hazard3_ahbl_aph_buf.sv - per-source address-phase capture buffer with live/buffered mux
module hazard3_ahbl_aph_buf #(
  parameter int W_ADDR = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_aph_vld,
  input  logic              i_issue,
  input  logic [W_ADDR-1:0] i_haddr,
  input  logic              i_hwrite,
  input  logic [2:0]        i_hsize,
  input  logic [3:0]        i_hprot,
  output logic              o_buf_vld,
  output logic              o_req,
  output logic [W_ADDR-1:0] o_haddr,
  output logic              o_hwrite,
  output logic [2:0]        o_hsize,
  output logic [3:0]        o_hprot
);

  logic              r_buf_vld;
  logic [W_ADDR-1:0] r_haddr;
  logic              r_hwrite;
  logic [2:0]        r_hsize;
  logic [3:0]        r_hprot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_vld <= 1'b0;
      r_haddr   <= '0;
      r_hwrite  <= 1'b0;
      r_hsize   <= 3'd0;
      r_hprot   <= 4'd0;
    end else if (r_buf_vld) begin
      if (i_issue)
        r_buf_vld <= 1'b0;
    end else if (i_aph_vld && !i_issue) begin
      r_buf_vld <= 1'b1;
      r_haddr   <= i_haddr;
      r_hwrite  <= i_hwrite;
      r_hsize   <= i_hsize;
      r_hprot   <= i_hprot;
    end
  end

  // The source holds off new aphs while full, so the buffer always wins the mux.
  assign o_buf_vld = r_buf_vld;
  assign o_req     = r_buf_vld || i_aph_vld;
  assign o_haddr   = r_buf_vld ? r_haddr  : i_haddr;
  assign o_hwrite  = r_buf_vld ? r_hwrite : i_hwrite;
  assign o_hsize   = r_buf_vld ? r_hsize  : i_hsize;
  assign o_hprot   = r_buf_vld ? r_hprot  : i_hprot;

endmodule

// File: rtl/hazard3_ahbl_arbiter2.sv
// rtl/hazard3_ahbl_arbiter2.sv - two-source AHB-Lite arbiter onto one downstream master port
module hazard3_ahbl_arbiter2 #(
  parameter int W_ADDR      = 32,
  parameter int W_DATA      = 32,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          src_hready,
  output logic [1:0]          src_hready_resp,
  output logic [1:0]          src_hresp,
  input  logic [2*W_ADDR-1:0] src_haddr,
  input  logic [1:0]          src_hwrite,
  input  logic [3:0]          src_htrans,
  input  logic [5:0]          src_hsize,
  input  logic [7:0]          src_hprot,
  input  logic [2*W_DATA-1:0] src_hwdata,
  output logic [2*W_DATA-1:0] src_hrdata,
  output logic [W_ADDR-1:0]   dst_haddr,
  output logic                dst_hwrite,
  output logic [1:0]          dst_htrans,
  output logic [2:0]          dst_hsize,
  output logic [3:0]          dst_hprot,
  output logic [W_DATA-1:0]   dst_hwdata,
  input  logic                dst_hready,
  input  logic                dst_hresp,
  input  logic [W_DATA-1:0]   dst_hrdata
);
  import hazard3_ahbl_arbiter2_pkg::*;

  logic [1:0]        w_aph_vld;
  logic [1:0]        w_req;
  logic [1:0]        w_buf_vld;
  logic [1:0]        w_gnt;
  logic [1:0]        w_issue;
  logic [W_ADDR-1:0] w_haddr [2];
  logic [1:0]        w_hwrite;
  logic [2:0]        w_hsize [2];
  logic [3:0]        w_hprot [2];
  logic              w_unused;

  logic              r_hold;
  logic [1:0]        r_gnt_prev;
  logic              r_last_gnt1;
  logic [1:0]        r_dph_owner;

  for (genvar i = 0; i < 2; i++) begin : g_src
    assign w_aph_vld[i] = src_htrans[2*i+1] && src_hready[i] && !rst;
    assign w_issue[i]   = w_gnt[i] && dst_hready;

    hazard3_ahbl_aph_buf #(.W_ADDR(W_ADDR)) u_aph_buf (
      .clk       (clk),
      .rst       (rst),
      .i_aph_vld (w_aph_vld[i]),
      .i_issue   (w_issue[i]),
      .i_haddr   (src_haddr[i*W_ADDR +: W_ADDR]),
      .i_hwrite  (src_hwrite[i]),
      .i_hsize   (src_hsize[3*i +: 3]),
      .i_hprot   (src_hprot[4*i +: 4]),
      .o_buf_vld (w_buf_vld[i]),
      .o_req     (w_req[i]),
      .o_haddr   (w_haddr[i]),
      .o_hwrite  (w_hwrite[i]),
      .o_hsize   (w_hsize[i]),
      .o_hprot   (w_hprot[i])
    );
  end

  // A stalled downstream aph must stay on the bus unchanged, so the grant is frozen.
  assign w_gnt = r_hold ? r_gnt_prev : arb_pick(w_req, r_last_gnt1, ROUND_ROBIN != 0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold      <= 1'b0;
      r_gnt_prev  <= 2'b00;
      r_last_gnt1 <= 1'b1;
      r_dph_owner <= 2'b00;
    end else begin
      r_hold     <= dst_htrans[1] && !dst_hready;
      r_gnt_prev <= w_gnt;
      if (dst_hready) begin
        r_dph_owner <= w_gnt;
        if (|w_gnt)
          r_last_gnt1 <= w_gnt[1];
      end
    end
  end

  always_comb begin
    dst_htrans = HTRANS_IDLE;
    dst_haddr  = '0;
    dst_hwrite = 1'b0;
    dst_hsize  = 3'd0;
    dst_hprot  = 4'd0;
    if (w_gnt[0]) begin
      dst_htrans = HTRANS_NSEQ;
      dst_haddr  = w_haddr[0];
      dst_hwrite = w_hwrite[0];
      dst_hsize  = w_hsize[0];
      dst_hprot  = w_hprot[0];
    end else if (w_gnt[1]) begin
      dst_htrans = HTRANS_NSEQ;
      dst_haddr  = w_haddr[1];
      dst_hwrite = w_hwrite[1];
      dst_hsize  = w_hsize[1];
      dst_hprot  = w_hprot[1];
    end
  end

  always_comb begin
    src_hready_resp = 2'b11;
    src_hresp       = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (r_dph_owner[i]) begin
        src_hready_resp[i] = dst_hready;
        src_hresp[i]       = dst_hresp;
      end else if (w_buf_vld[i] || (w_aph_vld[i] && !w_issue[i])) begin
        src_hready_resp[i] = 1'b0;
      end
    end
  end

  assign dst_hwdata = r_dph_owner[1] ? src_hwdata[W_DATA +: W_DATA] : src_hwdata[0 +: W_DATA];
  assign src_hrdata = {2{dst_hrdata}};

  assign w_unused = &{1'b0, src_htrans[0], src_htrans[2]};

endmodule
